// File: rtl/game_sequencer_pkg.sv
// ============================================================================
// Module      : game_sequencer_pkg
// Description : Shared states and constants for the game sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package game_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_PLAY = 3'd2,
    ST_HIT  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  localparam int          RESPAWN_CYCLES_DEFAULT = 25000000;
  localparam logic [15:0] BCD_MAX                = 16'h9999;
  localparam int          ARM_CYCLES             = 2;

endpackage

`default_nettype wire

// File: rtl/game_sequencer_bcd_counter4.sv
// ============================================================================
// Module      : bcd_counter4
// Description : 4-digit BCD counter with clear, increment and 9999 saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bcd_counter4
  import game_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_signal,
  input  logic        clear,
  input  logic        increment,
  output logic [15:0] count
);

  logic [15:0] w_next;
  logic        w_carry;

  // Ripple the +1 through the digits; a saturated count is left untouched.
  always_comb begin
    w_next  = count;
    w_carry = 1'b1;
    if (count != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (w_carry) begin
          if (count[4*i +: 4] == 4'd9) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = count[4*i +: 4] + 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      count <= 16'h0000;
    end else if (clear) begin
      count <= 16'h0000;
    end else if (increment) begin
      count <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
// Module      : game_sequencer
// Description : Game flow FSM: start, column arming, scoring, respawn, game over.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int RESPAWN_CYCLES = RESPAWN_CYCLES_DEFAULT
)
(
  input  logic        clock,
  input  logic        reset_signal,
  input  logic        start,
  input  logic        correct,
  input  logic        game_over,
  output logic        column_reset,
  output logic [15:0] score_bcd,
  output logic [15:0] high_score_bcd,
  output logic        playing,
  output logic        over,
  output logic        hit_pulse
);

  localparam int c_hit_w = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam int c_arm_w = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [c_hit_w-1:0] c_hit_last = c_hit_w'(RESPAWN_CYCLES - 1);
  localparam logic [c_arm_w-1:0] c_arm_last = c_arm_w'(ARM_CYCLES - 1);

  state_t               r_state;
  logic                 r_start_q;
  logic                 r_start_valid;
  logic [c_hit_w-1:0]   r_hit_cnt;
  logic [c_arm_w-1:0]   r_arm_cnt;

  logic w_start_rise;
  logic w_score_clr;
  logic w_score_inc;

  // r_start_valid masks the first cycle after reset so a held button is not a rise.
  assign w_start_rise = start & ~r_start_q & r_start_valid;
  assign w_score_clr  = w_start_rise & ((r_state == ST_IDLE) | (r_state == ST_OVER));
  assign w_score_inc  = (r_state == ST_PLAY) & correct;

  bcd_counter4 u_score (
    .clock        (clock),
    .reset_signal (reset_signal),
    .clear        (w_score_clr),
    .increment    (w_score_inc),
    .count        (score_bcd)
  );

  always_ff @(posedge clock) begin
    if (reset_signal) begin
      r_state        <= ST_IDLE;
      r_start_q      <= 1'b0;
      r_start_valid  <= 1'b0;
      r_hit_cnt      <= '0;
      r_arm_cnt      <= '0;
      column_reset   <= 1'b1;
      high_score_bcd <= 16'h0000;
      playing        <= 1'b0;
      over           <= 1'b0;
      hit_pulse      <= 1'b0;
    end else begin
      r_start_q     <= start;
      r_start_valid <= 1'b1;
      hit_pulse     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          column_reset <= 1'b1;
          playing      <= 1'b0;
          over         <= 1'b0;
          if (w_start_rise) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
            playing   <= 1'b1;
          end
        end
        ST_ARM: begin
          // Only the first ARM cycle holds the column in reset.
          column_reset <= 1'b0;
          if (r_arm_cnt == c_arm_last) begin
            r_state <= ST_PLAY;
          end else begin
            r_arm_cnt <= r_arm_cnt + c_arm_w'(1);
          end
        end
        ST_PLAY: begin
          column_reset <= 1'b0;
          if (correct) begin
            r_state   <= ST_HIT;
            r_hit_cnt <= '0;
            hit_pulse <= 1'b1;
          end else if (game_over) begin
            r_state <= ST_OVER;
            playing <= 1'b0;
            over    <= 1'b1;
            if (score_bcd > high_score_bcd) begin
              high_score_bcd <= score_bcd;
            end
          end
        end
        ST_HIT: begin
          if (r_hit_cnt == c_hit_last) begin
            r_state      <= ST_ARM;
            r_arm_cnt    <= '0;
            column_reset <= 1'b1;
          end else begin
            r_hit_cnt <= r_hit_cnt + c_hit_w'(1);
          end
        end
        ST_OVER: begin
          column_reset <= 1'b0;
          if (w_start_rise) begin
            r_state      <= ST_ARM;
            r_arm_cnt    <= '0;
            column_reset <= 1'b1;
            playing      <= 1'b1;
            over         <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          column_reset <= 1'b1;
          playing      <= 1'b0;
          over         <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_game_sequencer;

  logic        clock;
  logic        reset_signal;
  logic        start, correct, game_over;
  logic        column_reset, playing, over, hit_pulse;
  logic [15:0] score_bcd, high_score_bcd;

  logic        s_start, s_correct, s_game_over;
  logic        s_column_reset, s_playing, s_over, s_hit_pulse;
  logic [15:0] s_score_bcd, s_high_score_bcd;

  int checks = 0;
  int errors = 0;

  game_sequencer #(.RESPAWN_CYCLES(4)) dut (
    .clock          (clock),
    .reset_signal   (reset_signal),
    .start          (start),
    .correct        (correct),
    .game_over      (game_over),
    .column_reset   (column_reset),
    .score_bcd      (score_bcd),
    .high_score_bcd (high_score_bcd),
    .playing        (playing),
    .over           (over),
    .hit_pulse      (hit_pulse)
  );

  // Short respawn instance keeps the 9999 saturation run affordable.
  game_sequencer #(.RESPAWN_CYCLES(2)) s_dut (
    .clock          (clock),
    .reset_signal   (reset_signal),
    .start          (s_start),
    .correct        (s_correct),
    .game_over      (s_game_over),
    .column_reset   (s_column_reset),
    .score_bcd      (s_score_bcd),
    .high_score_bcd (s_high_score_bcd),
    .playing        (s_playing),
    .over           (s_over),
    .hit_pulse      (s_hit_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_hit();
    correct = 1'b1; step(); correct = 1'b0;
    repeat (6) step();
  endtask

  task automatic start_game();
    start = 1'b1; step(); start = 1'b0;
    step(); step();
  endtask

  task automatic end_game();
    game_over = 1'b1; step(); game_over = 1'b0;
  endtask

  task automatic test_reset();
    reset_signal = 1'b1; start = 0; correct = 0; game_over = 0;
    s_start = 0; s_correct = 0; s_game_over = 0;
    step(); step();
    checks++; if (column_reset !== 1'b1) begin errors++; $display("FAIL rst_colrst: got %b expected 1", column_reset); end
    checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL rst_score: got %h expected 0000", score_bcd); end
    checks++; if (high_score_bcd !== 16'h0000) begin errors++; $display("FAIL rst_high: got %h expected 0000", high_score_bcd); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b expected 0", hit_pulse); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL rst_playing: got %b expected 0", playing); end
    checks++; if (over !== 1'b0) begin errors++; $display("FAIL rst_over: got %b expected 0", over); end
    reset_signal = 1'b0; step();
    checks++; if (column_reset !== 1'b1 || playing !== 1'b0) begin errors++; $display("FAIL idle_hold: got colrst=%b playing=%b expected 1/0", column_reset, playing); end
  endtask

  task automatic test_start_arm();
    start = 1'b1; step();
    checks++; if (column_reset !== 1'b1 || playing !== 1'b1) begin errors++; $display("FAIL arm1: got colrst=%b playing=%b expected 1/1", column_reset, playing); end
    checks++; if (score_bcd !== 16'h0000) begin errors++; $display("FAIL arm1_score: got %h expected 0000", score_bcd); end
    correct = 1'b1; game_over = 1'b1; step();
    checks++; if (column_reset !== 1'b0 || playing !== 1'b1) begin errors++; $display("FAIL arm2: got colrst=%b playing=%b expected 0/1", column_reset, playing); end
    game_over = 1'b0; step();
    checks++; if (column_reset !== 1'b0 || hit_pulse !== 1'b0 || score_bcd !== 16'h0000) begin errors++; $display("FAIL play_entry: got colrst=%b hit=%b score=%h expected 0/0/0000", column_reset, hit_pulse, score_bcd); end
  endtask

  task automatic test_hit();
    // correct is still high from the ARM cycles; start still held in PLAY
    step();
    checks++; if (hit_pulse !== 1'b1 || score_bcd !== 16'h0001) begin errors++; $display("FAIL hit_first: got hit=%b score=%h expected 1/0001", hit_pulse, score_bcd); end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (hit_pulse !== 1'b0 || column_reset !== 1'b0 || score_bcd !== 16'h0001) begin errors++; $display("FAIL hit_hold%0d: got hit=%b colrst=%b score=%h expected 0/0/0001", i, hit_pulse, column_reset, score_bcd); end
    end
    step();
    checks++; if (column_reset !== 1'b1) begin errors++; $display("FAIL respawn_arm1: got %b expected 1", column_reset); end
    step();
    checks++; if (column_reset !== 1'b0) begin errors++; $display("FAIL respawn_arm2: got %b expected 0", column_reset); end
    step();
    correct = 1'b0; step();
    checks++; if (score_bcd !== 16'h0001 || hit_pulse !== 1'b0) begin errors++; $display("FAIL no_extra: got score=%h hit=%b expected 0001/0", score_bcd, hit_pulse); end
  endtask

  task automatic test_bcd_carry();
    repeat (9) do_hit();
    checks++; if (score_bcd !== 16'h0010) begin errors++; $display("FAIL bcd_0010: got %h expected 0010", score_bcd); end
    repeat (89) do_hit();
    checks++; if (score_bcd !== 16'h0099) begin errors++; $display("FAIL bcd_0099: got %h expected 0099", score_bcd); end
    correct = 1'b1; step(); correct = 1'b0;
    checks++; if (score_bcd !== 16'h0100 || hit_pulse !== 1'b1) begin errors++; $display("FAIL bcd_0100: got score=%h hit=%b expected 0100/1", score_bcd, hit_pulse); end
    repeat (6) step();
  endtask

  task automatic test_simultaneous();
    correct = 1'b1; game_over = 1'b1; step(); correct = 1'b0;
    checks++; if (score_bcd !== 16'h0101 || hit_pulse !== 1'b1 || over !== 1'b0) begin errors++; $display("FAIL both: got score=%h hit=%b over=%b expected 0101/1/0", score_bcd, hit_pulse, over); end
    repeat (6) step();
    checks++; if (over !== 1'b0 || playing !== 1'b1) begin errors++; $display("FAIL go_ignored: got over=%b playing=%b expected 0/1", over, playing); end
    step(); game_over = 1'b0;
    checks++; if (over !== 1'b1 || playing !== 1'b0 || column_reset !== 1'b0) begin errors++; $display("FAIL over_entry: got over=%b playing=%b colrst=%b expected 1/0/0", over, playing, column_reset); end
    checks++; if (high_score_bcd !== 16'h0101) begin errors++; $display("FAIL over_high: got %h expected 0101", high_score_bcd); end
    step();
    checks++; if (score_bcd !== 16'h0101 || over !== 1'b1) begin errors++; $display("FAIL over_hold: got score=%h over=%b expected 0101/1", score_bcd, over); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (score_bcd !== 16'h0000 || over !== 1'b0 || column_reset !== 1'b1 || playing !== 1'b1) begin errors++; $display("FAIL over_restart: got score=%h over=%b colrst=%b playing=%b expected 0000/0/1/1", score_bcd, over, column_reset, playing); end
  endtask

  task automatic test_high_score();
    reset_signal = 1'b1; step(); reset_signal = 1'b0; step();
    checks++; if (high_score_bcd !== 16'h0000 || score_bcd !== 16'h0000) begin errors++; $display("FAIL hs_reset: got high=%h score=%h expected 0000/0000", high_score_bcd, score_bcd); end
    start_game(); repeat (2) do_hit(); end_game();
    checks++; if (over !== 1'b1 || high_score_bcd !== 16'h0002) begin errors++; $display("FAIL hs_game1: got over=%b high=%h expected 1/0002", over, high_score_bcd); end
    start_game(); repeat (3) do_hit(); end_game();
    checks++; if (high_score_bcd !== 16'h0003 || score_bcd !== 16'h0003) begin errors++; $display("FAIL hs_game2: got high=%h score=%h expected 0003/0003", high_score_bcd, score_bcd); end
    start_game(); do_hit(); end_game();
    checks++; if (high_score_bcd !== 16'h0003 || score_bcd !== 16'h0001) begin errors++; $display("FAIL hs_game3: got high=%h score=%h expected 0003/0001", high_score_bcd, score_bcd); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (score_bcd !== 16'h0000 || playing !== 1'b1 || over !== 1'b0) begin errors++; $display("FAIL hs_restart: got score=%h playing=%b over=%b expected 0000/1/0", score_bcd, playing, over); end
    step(); step();
  endtask

  task automatic test_reset_mid_hit();
    repeat (4) do_hit();
    correct = 1'b1; step(); correct = 1'b0; step();
    checks++; if (score_bcd !== 16'h0005) begin errors++; $display("FAIL mid_score: got %h expected 0005", score_bcd); end
    reset_signal = 1'b1; start = 1'b1; step();
    checks++; if (column_reset !== 1'b1 || score_bcd !== 16'h0000 || high_score_bcd !== 16'h0000) begin errors++; $display("FAIL mid_rst_a: got colrst=%b score=%h high=%h expected 1/0000/0000", column_reset, score_bcd, high_score_bcd); end
    checks++; if (hit_pulse !== 1'b0 || playing !== 1'b0 || over !== 1'b0) begin errors++; $display("FAIL mid_rst_b: got hit=%b playing=%b over=%b expected 0/0/0", hit_pulse, playing, over); end
    reset_signal = 1'b0; step(); step();
    checks++; if (playing !== 1'b0 || column_reset !== 1'b1) begin errors++; $display("FAIL held_start: got playing=%b colrst=%b expected 0/1", playing, column_reset); end
    start = 1'b0; step(); start = 1'b1; step(); start = 1'b0;
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL new_rise: got playing=%b expected 1", playing); end
  endtask

  task automatic test_saturation();
    s_start = 1'b1; step(); s_start = 1'b0; step(); step();
    for (int i = 0; i < 999; i++) begin
      s_correct = 1'b1; step(); s_correct = 1'b0; repeat (4) step();
    end
    checks++; if (s_score_bcd !== 16'h0999) begin errors++; $display("FAIL sat_0999: got %h expected 0999", s_score_bcd); end
    s_correct = 1'b1; step(); s_correct = 1'b0; repeat (4) step();
    checks++; if (s_score_bcd !== 16'h1000) begin errors++; $display("FAIL sat_1000: got %h expected 1000", s_score_bcd); end
    for (int i = 0; i < 8999; i++) begin
      s_correct = 1'b1; step(); s_correct = 1'b0; repeat (4) step();
    end
    checks++; if (s_score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_9999: got %h expected 9999", s_score_bcd); end
    s_correct = 1'b1; step(); s_correct = 1'b0;
    checks++; if (s_score_bcd !== 16'h9999 || s_hit_pulse !== 1'b1) begin errors++; $display("FAIL sat_hold: got score=%h hit=%b expected 9999/1", s_score_bcd, s_hit_pulse); end
    step();
    checks++; if (s_hit_pulse !== 1'b0) begin errors++; $display("FAIL sat_pulse_end: got %b expected 0", s_hit_pulse); end
  endtask

  initial begin
    test_reset();
    test_start_arm();
    test_hit();
    test_bcd_carry();
    test_simultaneous();
    test_high_score();
    test_reset_mid_hit();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL provide parameter RESPAWN_CYCLES, default 25000000, number of clock cycles spent in HIT before the column is respawned (minimum 2).
REQ-002 SHALL have port clock  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 SHALL have port reset_signal  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  active-high start button level, already debounced and inverted upstream.
REQ-005 SHALL have port correct  input  1  latched "letter matched" flag from the column stage.
REQ-006 SHALL have port game_over  input  1  latched "column reached bottom" flag from the column stage.
REQ-007 SHALL have port column_reset  output  1  drives the column stage's reset_signal.
REQ-008 SHALL have port score_bcd  output  16  current score, 4 BCD digits, digit 3 in [15:12].
REQ-009 SHALL have port high_score_bcd  output  16  best score since reset, same format.
REQ-010 SHALL have port playing  output  1  high in states ARM, PLAY and HIT.
REQ-011 SHALL have port over  output  1  high in state OVER.
REQ-012 SHALL have port hit_pulse  output  1  one-cycle pulse on each score increment.

Function
REQ-013 SHALL detect start rising edges with a one-cycle registered delay: rise = start & ~start_q.
REQ-014 SHALL implement the states IDLE, ARM, PLAY, HIT and OVER; all outputs are registered.
REQ-015 IDLE: column_reset held at 1; on a start rise, clear score_bcd to 0 and go to ARM.
REQ-016 ARM: lasts exactly 2 cycles; cycle 1 drives column_reset=1, cycle 2 drives column_reset=0; correct and game_over are ignored in both cycles; then go to PLAY.
REQ-017 PLAY: column_reset=0; if correct=1, increment the score, pulse hit_pulse and go to HIT.
REQ-018 PLAY: else if game_over=1, go to OVER.
REQ-019 PLAY: if correct and game_over are both 1 in the same cycle, correct wins (REQ-017).
REQ-020 PLAY: start is ignored.
REQ-021 HIT: remain for exactly RESPAWN_CYCLES cycles, ignoring all inputs; then go to ARM, keeping the score.
REQ-022 OVER: column_reset=0, so the column stays frozen where it ended; the score stays visible.
REQ-023 On entry to OVER, load high_score_bcd with score_bcd if score_bcd is greater.
REQ-024 OVER: on a start rise, clear the score and go to ARM.
REQ-025 Score arithmetic SHALL be 4-digit BCD: a digit value of 9 wraps to 0 with carry; the score saturates at 9999, and hit_pulse still fires at saturation.
REQ-026 The HIT counter SHALL be sized to hold RESPAWN_CYCLES-1 and SHALL restart from 0 on every HIT entry.
REQ-027 Outputs SHALL never take undefined or unlisted state encodings; any illegal state returns to IDLE on the next cycle.

Reset
REQ-028 While reset_signal=1 at a clock edge, the block SHALL: enter IDLE; drive column_reset=1; clear score_bcd, high_score_bcd, hit_pulse, playing and over to 0; clear start_q and the HIT counter.
REQ-029 Reset asserted mid-game (any state) SHALL take effect on that edge with no further score or high-score update.
REQ-030 A start held high through reset release SHALL NOT count as a rise.

Structure
REQ-031 A shared package SHALL hold: the state enumeration, the RESPAWN_CYCLES default, BCD_MAX = 16'h9999, and the ARM length of 2.
REQ-032 A sub-module bcd_counter4 SHALL provide the clear, increment and saturate behaviour of REQ-025; it SHALL be instantiated for the score.
REQ-033 The high-score compare SHALL be a plain 16-bit unsigned compare, which is valid for BCD.

Verification (RESPAWN_CYCLES=4)
REQ-034 Reset, then start rise -> column_reset high through IDLE; then 1, 0 in the ARM cycles; PLAY on the 3rd cycle after the rise is registered; score 0000.
REQ-035 In PLAY, correct=1 -> hit_pulse for 1 cycle, score 0001, HIT for 4 cycles, ARM pulse, back to PLAY; correct held high during HIT and ARM -> no extra increment.
REQ-036 Score preset to 0099 via 99 hits, one more hit -> 0100; preset 9999, one more hit -> stays 9999 with hit_pulse=1.
REQ-037 correct and game_over asserted in the same PLAY cycle -> score +1, HIT entered, over stays 0.
REQ-038 game_over at score 0003 with high score 0002 -> OVER, high_score_bcd 0003; new game ending at 0001 -> high score stays 0003; start rise in OVER -> score 0000, ARM.
REQ-039 reset_signal pulsed during HIT with score 0005 -> next cycle in IDLE, all outputs zero except column_reset=1; start held high across release -> stays IDLE.
